// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end.
// Imported by the fetch stage and its interface users.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        FULL,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory, redirect input and
// the valid/ready link to decode.
interface fetch_unit_if #(
    parameter int XLEN = cpu_pkg::XLEN
);

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            redirect_i;
    logic [XLEN-1:0] redirect_pc_i;
    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        input  redirect_i,
        input  redirect_pc_i,
        output instr_valid_o,
        input  instr_ready_i,
        output instr_o,
        output pc_o,
        output pc_plus4_o
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i,
        output redirect_i,
        output redirect_pc_i,
        input  instr_valid_o,
        output instr_ready_i,
        input  instr_o,
        input  pc_o,
        input  pc_plus4_o
    );

endinterface

// File: rtl/pc_register.sv
// Fetch PC flop: redirect load wins over the +4 step taken when
// a fetch response is accepted.
module pc_register #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] target,
    input  logic            incr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= {target[XLEN-1:2], 2'b00};
        end else if (incr) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a one-entry
// output buffer towards decode, and redirect/flush handling.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'hBFC0_0000
) (
    input logic         clk_i,
    input logic         rst_i,
    fetch_unit_if.master bus
);

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic            out_valid;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] fetch_pc;
    logic            redirect;
    logic            rvalid;
    logic            accept;
    logic            xfer;

    assign redirect = bus.redirect_i;
    assign rvalid   = bus.imem_rvalid_i;
    assign accept   = (state == WAIT) && rvalid && !redirect;
    assign xfer     = bus.instr_valid_o && bus.instr_ready_i;

    pc_register #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (redirect),
        .target (bus.redirect_pc_i),
        .incr   (accept),
        .pc     (fetch_pc)
    );

    assign bus.imem_addr_o = fetch_pc;
    assign bus.imem_req_o  = !rst_i && !redirect &&
                             ((state == ISSUE) ||
                              ((state == FULL) && bus.instr_ready_i));

    always_comb begin
        state_n = state;
        if (redirect) begin
            // A request still in flight must have its response swallowed
            if (((state == WAIT) && !rvalid) || (state == DROP)) begin
                state_n = DROP;
            end else begin
                state_n = ISSUE;
            end
        end else begin
            unique case (state)
                ISSUE: state_n = WAIT;
                WAIT:  if (rvalid) state_n = FULL;
                FULL:  if (bus.instr_ready_i) state_n = WAIT;
                DROP:  if (rvalid) state_n = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ISSUE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_pc    <= '0;
        end else if (redirect) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= bus.imem_rdata_i;
            out_pc    <= fetch_pc;
        end else if (xfer) begin
            out_valid <= 1'b0;
        end
    end

    assign bus.instr_valid_o = out_valid && !rst_i;
    assign bus.instr_o       = out_instr;
    assign bus.pc_o          = out_pc;
    assign bus.pc_plus4_o    = out_pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency imem model.
// Table of per-cycle vectors plus redirect/reset corner sequences.
module tb_fetch_unit;
    import cpu_pkg::*;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        v;
        logic [31:0] pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   lat = 1;
    int   cnt = 0;
    logic [31:0] pend;
    logic        m_fire;
    logic        m_rst;
    logic [31:0] m_addr;
    vec_t        tv[16];

    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'hBFC0_0000)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        if (a == 32'hBFC0_000C) return 32'h0050_0093;
        return {~a[31:2], 2'b11};
    endfunction

    // Instruction memory: response exactly lat cycles after request
    always @(posedge clk) begin
        m_fire = bus.imem_req_o;
        m_addr = bus.imem_addr_o;
        m_rst  = rst;
        #1;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        if (m_rst) begin
            cnt = 0;
        end else begin
            if (m_fire) begin
                pend = m_addr;
                cnt  = lat;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    bus.imem_rvalid_i = 1'b1;
                    bus.imem_rdata_i  = word(pend);
                end
            end
        end
    end

    task automatic set_in(input logic r, input logic rdy,
                          input logic rd, input logic [31:0] rpc);
        rst               = r;
        bus.instr_ready_i = rdy;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
    endtask

    task automatic chk(input string nm, input logic e_req,
                       input logic [31:0] e_addr, input logic e_v,
                       input logic [31:0] e_pc);
        @(negedge clk);
        n_vec++;
        if (bus.imem_req_o !== e_req || bus.imem_addr_o !== e_addr ||
            bus.instr_valid_o !== e_v ||
            (e_v && (bus.pc_o !== e_pc || bus.instr_o !== word(e_pc) ||
                     bus.pc_plus4_o !== e_pc + 32'd4))) begin
            n_bad++;
            $display("FAIL %s: got req=%b addr=%h v=%b pc=%h instr=%h pc4=%h want req=%b addr=%h v=%b pc=%h instr=%h pc4=%h",
                     nm, bus.imem_req_o, bus.imem_addr_o, bus.instr_valid_o,
                     bus.pc_o, bus.instr_o, bus.pc_plus4_o,
                     e_req, e_addr, e_v, e_pc,
                     e_v ? word(e_pc) : 32'h0, e_pc + 32'd4);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        tv[0]  = '{1'b1, 1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 32'h0};
        tv[2]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0000, 1'b0, 32'h0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000};
        tv[4]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0004, 1'b0, 32'h0};
        tv[5]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0008, 1'b1, 32'hBFC0_0004};
        tv[6]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0008, 1'b0, 32'h0};
        tv[7]  = '{1'b0, 1'b1, 1'b1, 32'hBFC0_000C, 1'b1, 32'hBFC0_0008};
        tv[8]  = '{1'b0, 1'b1, 1'b0, 32'hBFC0_000C, 1'b0, 32'h0};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
        tv[10] = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
        tv[11] = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
        tv[12] = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
        tv[13] = '{1'b0, 1'b0, 1'b0, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
        tv[14] = '{1'b0, 1'b1, 1'b1, 32'hBFC0_0010, 1'b1, 32'hBFC0_000C};
        tv[15] = '{1'b0, 1'b1, 1'b0, 32'hBFC0_0010, 1'b0, 32'h0};

        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            set_in(tv[i].rst, tv[i].rdy, 1'b0, 32'h0);
            chk($sformatf("vec%0d", i), tv[i].req, tv[i].addr,
                tv[i].v, tv[i].pc);
        end

        // Reset while FULL: valid gated, then restart at RESET_PC
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        chk("rst_hold0", 1'b0, 32'hBFC0_0014, 1'b0, 32'h0);
        chk("rst_hold1", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);

        // Latency 3, redirect one cycle after the request
        lat = 3;
        chk("b_req", 1'b1, 32'hBFC0_0000, 1'b0, 32'h0);
        set_in(1'b0, 1'b1, 1'b1, 32'h0000_0100);
        chk("b_redir", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        chk("b_drop0", 1'b0, 32'h0000_0100, 1'b0, 32'h0);
        chk("b_drop1", 1'b0, 32'h0000_0100, 1'b0, 32'h0);
        chk("b_reissue", 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        chk("b_wait0", 1'b0, 32'h0000_0100, 1'b0, 32'h0);
        chk("b_wait1", 1'b0, 32'h0000_0100, 1'b0, 32'h0);
        chk("b_wait2", 1'b0, 32'h0000_0100, 1'b0, 32'h0);
        lat = 1;
        chk("b_deliver", 1'b1, 32'h0000_0104, 1'b1, 32'h0000_0100);

        // Misaligned redirect coincident with rvalid
        set_in(1'b0, 1'b1, 1'b1, 32'h0000_0203);
        chk("c_redir", 1'b0, 32'h0000_0104, 1'b0, 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        chk("c_reissue", 1'b1, 32'h0000_0200, 1'b0, 32'h0);
        chk("c_wait", 1'b0, 32'h0000_0200, 1'b0, 32'h0);

        // Redirect while FULL with ready: old one delivered once
        set_in(1'b0, 1'b1, 1'b1, 32'h0000_0300);
        chk("d_xfer", 1'b0, 32'h0000_0204, 1'b1, 32'h0000_0200);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        chk("d_issue", 1'b1, 32'h0000_0300, 1'b0, 32'h0);
        chk("d_wait", 1'b0, 32'h0000_0300, 1'b0, 32'h0);
        lat = 3;
        chk("d_deliver", 1'b1, 32'h0000_0304, 1'b1, 32'h0000_0300);

        // Reset mid-WAIT for two cycles
        set_in(1'b1, 1'b1, 1'b0, 32'h0);
        chk("e_rst0", 1'b0, 32'h0000_0304, 1'b0, 32'h0);
        chk("e_rst1", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0);
        set_in(1'b0, 1'b1, 1'b0, 32'h0);
        chk("e_req", 1'b1, 32'hBFC0_0000, 1'b0, 32'h0);
        chk("e_wait0", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0);
        chk("e_wait1", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0);
        chk("e_wait2", 1'b0, 32'hBFC0_0000, 1'b0, 32'h0);
        set_in(1'b0, 1'b0, 1'b0, 32'h0);
        chk("e_full", 1'b0, 32'hBFC0_0004, 1'b1, 32'hBFC0_0000);
        set_in(1'b1, 1'b0, 1'b0, 32'h0);
        chk("e_rstgate", 1'b0, 32'hBFC0_0004, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decode logic (main decoder, ALU control, immediate extend). Holds the fetch PC and issues one outstanding request at a time to instruction memory. Buffers the returned instruction word, with its PC and PC+4, in a one-entry output register and presents it to decode under a valid/ready handshake. Accepts redirects (taken branch, JAL, JALR) from execute and flushes any in-flight or buffered instruction.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch address of the first instruction after reset
XLEN, 32, address/instruction width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous active-high reset
imem_req_o  output  1  fetch request to instruction memory, one-cycle pulse per request
imem_addr_o  output  XLEN  word-aligned fetch address, valid when imem_req_o=1
imem_rvalid_i  input  1  response valid, one cycle, any latency >=1 cycle after request
imem_rdata_i  input  XLEN  instruction word, valid with imem_rvalid_i
redirect_i  input  1  redirect fetch (branch taken / JAL / JALR)
redirect_pc_i  input  XLEN  redirect target
instr_valid_o  output  1  output register holds an instruction for decode
instr_ready_i  input  1  decode accepts instruction this cycle
instr_o  output  XLEN  instruction word to decode (opcode = bits [6:0])
pc_o  output  XLEN  PC of instr_o
pc_plus4_o  output  XLEN  pc_o + 4, link value for JAL/JALR

Behaviour:
- States: ISSUE, WAIT, FULL, DROP. Internal registers: fetch_pc, out_valid, out_instr, out_pc.
- Reset (rst_i=1 at an edge): state=ISSUE, fetch_pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0.
- Output values while rst_i=1: imem_req_o=0 (gated by rst_i), instr_valid_o=0.
- First cycle after reset: imem_req_o=1, imem_addr_o=RESET_PC.
- Transfer to decode occurs when instr_valid_o && instr_ready_i.
- imem_addr_o = fetch_pc always.
- imem_req_o = !rst_i && !redirect_i && (state==ISSUE || (state==FULL && instr_ready_i)).
- ISSUE: request asserted -> WAIT.
- WAIT, on imem_rvalid_i:
  - out_instr=imem_rdata_i, out_pc=fetch_pc, out_valid=1.
  - fetch_pc += 4 (mod 2^32; wraps 0xFFFF_FFFC -> 0).
  - Next state FULL. No rvalid: stay WAIT.
- FULL: instr_valid_o=1; outputs held stable while instr_ready_i=0.
- FULL with transfer: out_valid=0, request for fetch_pc issued same cycle -> WAIT. Peak throughput is 1 instruction per 2 cycles at 1-cycle memory latency.
- Redirect has priority over every other event in every state:
  - fetch_pc <= {redirect_pc_i[XLEN-1:2], 2'b00} (misaligned low bits cleared); out_valid <= 0; no request that cycle.
  - From WAIT without same-cycle rvalid -> DROP.
  - From WAIT with same-cycle rvalid: response discarded -> ISSUE.
  - From ISSUE or FULL -> ISSUE.
  - From DROP: stay DROP; fetch_pc updated again, last redirect wins.
- Redirect coincident with a decode transfer in FULL: the transferred instruction counts as delivered (decode owns the squash decision); the buffer still clears.
- DROP: the next imem_rvalid_i is discarded, no output update, then -> ISSUE. At most one outstanding request exists at any time.
- imem_rvalid_i in ISSUE or FULL is a protocol error: ignored, no state change.
- pc_plus4_o = out_pc + 4, combinational from the register.
- instr_o, pc_o and pc_plus4_o are registered or derived from registers only; no combinational path from imem_rdata_i.
- Reset asserted mid-WAIT: a later stale rvalid arrives while in ISSUE/WAIT. The memory is reset by the same rst_i, so no stale response is required to be handled.

Decomposition:
- Shared package (cpu_pkg): RESET_PC_DEFAULT, XLEN, NOP_INSTR=32'h0000_0013, typedef enum logic [1:0] fetch_state_t {ISSUE, WAIT, FULL, DROP}.
- One sub-module, pc_register: fetch_pc flop with synchronous reset to RESET_PC, priority load (redirect) over increment (+4 on accepted response).
- FSM and output buffer live in fetch_unit.

Test Plan:
- Reset released, memory latency 1, ready=1 -> req at 0xBFC00000, instr_valid_o pulses with pc_o=0xBFC00000, 0xBFC00004, 0xBFC00008 every 2 cycles; pc_plus4_o=pc_o+4.
- ready=0 for 5 cycles while FULL with instr 0x00500093 -> instr_valid_o, instr_o, pc_o constant, imem_req_o=0; ready=1 -> transfer plus request for next PC same cycle.
- Latency 3, redirect to 0x00000100 one cycle after request -> DROP, returned word discarded, next req addr 0x100, first delivered pc_o=0x100.
- Redirect to 0x00000203 in the same cycle as rvalid -> word discarded, no instr_valid_o, next req addr 0x200.
- Redirect while FULL with ready=1 -> old instruction transferred once, buffer cleared, next delivered pc_o=redirect target.
- rst_i asserted mid-WAIT for 2 cycles -> instr_valid_o=0, imem_req_o=0 during reset, req at RESET_PC the cycle after release.
